ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends command bytes (LED set 0xED, reset 0xFF, typematic 0xF3, ...) to the keyboard over the same open-drain clock/data pair the keyboard receiver listens on.
- Performs the PS/2 request-to-send sequence, shifts out data, parity and stop on device-generated clocks, checks the device ACK, and reports done or error to the CPU-side logic.
- Lines are driven only low, through output-enable signals; the top level builds the open-drain pads.

Parameters:
- INHIBIT_CYCLES, 2500, clk25 cycles the host holds clock low (100 us at 25 MHz).
- SETUP_CYCLES, 25, cycles data is held low before clock is released (1 us).
- TIMEOUT_CYCLES, 375000, maximum clk25 cycles allowed between device clock falling edges (15 ms).
- FILTER_CYCLES, 8, cycles the synchronized key_clk must be stable before the filtered clock changes.

Ports:
- clk25  in  1  25 MHz clock, sole clock.
- rst  in  1  synchronous reset, active-high.
- key_clk  in  1  PS/2 clock pad input (asynchronous).
- key_din  in  1  PS/2 data pad input (asynchronous).
- key_clk_oe  out  1  1 = pull PS/2 clock low.
- key_din_oe  out  1  1 = pull PS/2 data low.
- tx_data  in  8  command byte to send.
- tx_start  in  1  one-cycle request; accepted only when busy=0.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse: byte sent and ACK received.
- err  out  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Reset: key_clk_oe=0, key_din_oe=0, busy=0, done=0, err=0, state=IDLE, counters=0. Reset mid-transfer releases both lines on the next edge and emits no pulse.
- Input conditioning: key_clk and key_din pass through 2-FF synchronizers. The filtered clock changes only after the synchronized key_clk has held a new value for FILTER_CYCLES consecutive cycles. A falling edge is filtered 1→0, detected on one cycle.
- IDLE: both oe=0. When tx_start=1, latch tx_data, compute parity = ~^tx_data (odd parity), set busy=1 on the next cycle, go to INHIBIT. tx_start while busy=1 is ignored, and the latched byte does not change.
- INHIBIT: key_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to SETUP.
- SETUP: key_clk_oe=1 and key_din_oe=1 (start bit 0) for SETUP_CYCLES cycles. Then key_clk_oe goes 0 and key_din_oe stays 1; go to SHIFT with bit index 0 and the timeout counter cleared.
- SHIFT: on each filtered falling edge, drive the next bit, with key_din_oe = ~bit:
  - edges 1-8: data bits 0-7, LSB first;
  - edge 9: parity;
  - edge 10: stop bit, key_din_oe=0;
  - then go to ACK.
- ACK: on the next filtered falling edge (edge 11), sample synchronized key_din.
  - 0: go to WAIT_IDLE with result=ok.
  - 1: result=fail, go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock=1 and synchronized data=1.
  - On that cycle, pulse done if ok or err if fail, clear busy, return to IDLE.
  - done and err are never both 1.
- Timeout: in SHIFT, ACK and WAIT_IDLE, a counter increments every cycle and clears on each filtered falling edge. Reaching TIMEOUT_CYCLES forces both oe=0, pulses err, clears busy and returns to IDLE.
- Host drives data only while clock is low (after a falling edge), never during INHIBIT release.
- Latency from tx_start to clock release = 1 + INHIBIT_CYCLES + SETUP_CYCLES cycles, ±1.
- All counters are sized for their parameter values; no wrap-around occurs within a state.

Test Plan:
- Reset with lines idle high → all outputs 0, busy=0; assert rst during SHIFT → both oe=0 the next cycle, no done or err pulse.
- tx_data=0xED, tx_start pulse, device model clocks at ~12.5 kHz and ACKs → key_clk_oe low for 2500 cycles, start bit 0, device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; single done pulse; busy=0 afterwards.
- tx_data=0xFF, device leaves data high at edge 11 → parity sampled 1, err pulse, no done.
- tx_start, device never clocks after release → err exactly TIMEOUT_CYCLES (±2) after clock release, both oe=0, busy=0.
- tx_start pulsed again mid-transfer with tx_data=0x00 → ignored; original byte completes unchanged.
- Inject 5-cycle low glitches on key_clk during SHIFT → no bit advance; full byte 0xF3 with parity 1 still received correctly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, shifts data/parity/stop on device clocks,
// checks the device ACK and reports done/err. Lines are only ever pulled low via *_oe.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned SETUP_CYCLES   = 25,
    parameter int unsigned TIMEOUT_CYCLES = 375000,
    parameter int unsigned FILTER_CYCLES  = 8
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       key_clk,
    input  logic       key_din,
    output logic       key_clk_oe,
    output logic       key_din_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CYC_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLT_W   = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned BIT_W   = 4;

    localparam logic [CYC_W-1:0] INHIBIT_LAST = CYC_W'(INHIBIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] SETUP_LAST   = CYC_W'(SETUP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST     = FLT_W'(FILTER_CYCLES - 1);
    localparam logic [BIT_W-1:0] PARITY_IDX   = BIT_W'(8);
    localparam logic [BIT_W-1:0] STOP_IDX     = BIT_W'(9);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        SETUP     = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t state, state_d;

    logic [1:0]       clk_sync_q;
    logic [1:0]       din_sync_q;
    logic             clk_sync;
    logic             din_sync;
    logic             filt_clk;
    logic [FLT_W-1:0] filt_cnt;
    logic             fall;

    logic [7:0]       data_q;
    logic             par_q;
    logic [CYC_W-1:0] cyc_cnt;
    logic [BIT_W-1:0] bit_idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ack_ok;

    logic             cyc_done;
    logic             tmo_hit;
    logic             line_idle;

    logic             clk_oe_d;
    logic             din_oe_d;
    logic             busy_d;
    logic             done_d;
    logic             err_d;

    assign clk_sync = clk_sync_q[1];
    assign din_sync = din_sync_q[1];

    // Two-flop synchronizers; lines idle high out of reset.
    always_ff @(posedge clk25) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            din_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], key_clk};
            din_sync_q <= {din_sync_q[0], key_din};
        end
    end

    // Glitch filter: follow the synchronized clock only after it holds a new level long enough.
    always_ff @(posedge clk25) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= filt_clk && !clk_sync && (filt_cnt == FLT_LAST);
            if (clk_sync != filt_clk) begin
                if (filt_cnt == FLT_LAST) begin
                    filt_clk <= clk_sync;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FLT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign cyc_done  = (cyc_cnt == ((state == INHIBIT) ? INHIBIT_LAST : SETUP_LAST));
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign line_idle = filt_clk && din_sync;

    // Byte latch, phase counters, bit index, timeout and ACK result.
    always_ff @(posedge clk25) begin
        if (rst) begin
            data_q  <= '0;
            par_q   <= 1'b0;
            cyc_cnt <= '0;
            bit_idx <= '0;
            tmo_cnt <= '0;
            ack_ok  <= 1'b0;
        end else begin
            if (state == IDLE && tx_start) begin
                data_q <= tx_data;
                par_q  <= ~^tx_data;
            end

            if ((state == INHIBIT || state == SETUP) && !cyc_done) begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end else begin
                cyc_cnt <= '0;
            end

            if (state != SHIFT) begin
                bit_idx <= '0;
            end else if (fall) begin
                bit_idx <= bit_idx + BIT_W'(1);
            end

            if ((state == SHIFT || state == ACK || state == WAIT_IDLE) && !fall) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            if (state == ACK && fall) begin
                ack_ok <= !din_sync;
            end
        end
    end

    // State register.
    always_ff @(posedge clk25) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (tx_start) state_d = INHIBIT;
            INHIBIT:   if (cyc_done) state_d = SETUP;
            SETUP:     if (cyc_done) state_d = SHIFT;
            SHIFT: begin
                if (fall) begin
                    if (bit_idx == STOP_IDX) state_d = ACK;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (fall)         state_d = WAIT_IDLE;
                else if (tmo_hit) state_d = IDLE;
            end
            WAIT_IDLE: begin
                if (line_idle || tmo_hit) state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered pad enables and status flags.
    always_comb begin
        clk_oe_d = 1'b0;
        din_oe_d = key_din_oe;
        busy_d   = busy;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state)
            IDLE: begin
                din_oe_d = 1'b0;
                clk_oe_d = tx_start;
                busy_d   = tx_start;
            end
            INHIBIT: begin
                clk_oe_d = 1'b1;
                din_oe_d = cyc_done;
            end
            SETUP: begin
                clk_oe_d = !cyc_done;
                din_oe_d = 1'b1;
            end
            SHIFT: begin
                if (fall) begin
                    if (bit_idx < PARITY_IDX)       din_oe_d = ~data_q[bit_idx[2:0]];
                    else if (bit_idx == PARITY_IDX) din_oe_d = ~par_q;
                    else                            din_oe_d = 1'b0;
                end else if (tmo_hit) begin
                    din_oe_d = 1'b0;
                    busy_d   = 1'b0;
                    err_d    = 1'b1;
                end
            end
            ACK: begin
                din_oe_d = 1'b0;
                if (!fall && tmo_hit) begin
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                end
            end
            WAIT_IDLE: begin
                din_oe_d = 1'b0;
                if (line_idle) begin
                    busy_d = 1'b0;
                    done_d = ack_ok;
                    err_d  = !ack_ok;
                end else if (tmo_hit) begin
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                end
            end
            default: begin
                din_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk25) begin
        if (rst) begin
            key_clk_oe <= 1'b0;
            key_din_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            key_clk_oe <= clk_oe_d;
            key_din_oe <= din_oe_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model plus a behavioural PS/2 keyboard that clocks
// the frame in, compares it with the expected frame and ACKs or withholds ACK.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 100;
    localparam int unsigned SET  = 10;
    localparam int unsigned TMO  = 3000;
    localparam int unsigned FLT  = 8;
    localparam int unsigned HALF = 40;

    logic       clk25;
    logic       rst;
    logic       key_clk;
    logic       key_din;
    logic       key_clk_oe;
    logic       key_din_oe;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       err;
    logic       dev_clk_low;
    logic       dev_din_low;

    int checks;
    int failures;
    int done_n;
    int err_n;
    int both_n;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_CYCLES (FLT)
    ) dut (
        .clk25     (clk25),
        .rst       (rst),
        .key_clk   (key_clk),
        .key_din   (key_din),
        .key_clk_oe(key_clk_oe),
        .key_din_oe(key_din_oe),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Wired-AND open-drain bus with pull-ups.
    assign key_clk = !(key_clk_oe || dev_clk_low);
    assign key_din = !(key_din_oe || dev_din_low);

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    always @(posedge clk25) begin
        #1;
        if (done)        done_n++;
        if (err)         err_n++;
        if (done && err) both_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk25);
    endtask

    // Expected frame as the device sees it: data LSB first, odd parity, stop=1.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // One device clock pulse; the device reads data just before raising its clock.
    task automatic pulse(input bit glitch, input bit poke, output logic smp);
        dev_clk_low = 1'b1;
        repeat (HALF) tick();
        smp = key_din;
        dev_clk_low = 1'b0;
        for (int c = 0; c < int'(HALF); c++) begin
            dev_clk_low = glitch && c >= 15 && c < 20;
            if (poke && c == 10) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            tick();
        end
        dev_clk_low = 1'b0;
        tx_start    = 1'b0;
    endtask

    // Request a transfer and wait for the host to release the clock.
    task automatic start_and_release(input logic [7:0] data, input string tag, output bit released);
        int lat;
        int inh;
        lat = 0;
        inh = 0;
        tx_data  = data;
        tx_start = 1'b1;
        do begin
            tick();
            tx_start = 1'b0;
            lat++;
            if (key_clk_oe && !key_din_oe) inh++;
        end while (key_clk_oe && lat < int'(4 * (INH + SET)));
        released = !key_clk_oe;
        check({tag, "_released"}, 32'(released), 32'd1);
        check({tag, "_inhibit_len"}, 32'(inh), 32'(INH));
        check({tag, "_latency_ok"}, 32'(lat >= int'(INH + SET) && lat <= int'(INH + SET + 2)), 32'd1);
        check({tag, "_start_bit"}, 32'(key_din), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic xfer(input logic [7:0] data, input bit ack, input bit glitch, input bit poke,
                        input string tag);
        int d0;
        int e0;
        int w;
        bit rel;
        logic smp;
        logic [9:0] got;
        d0 = done_n;
        e0 = err_n;
        start_and_release(data, tag, rel);
        repeat (20) tick();
        for (int p = 0; p < 10; p++) begin
            pulse(glitch && p >= 2 && p <= 8, poke && p == 3, smp);
            got[p] = smp;
        end
        check({tag, "_frame"}, 32'(got), 32'(frame_of(data)));
        dev_din_low = ack;
        repeat (5) tick();
        pulse(1'b0, 1'b0, smp);
        repeat (5) tick();
        dev_din_low = 1'b0;
        w = 0;
        while (busy && w < 500) begin
            tick();
            w++;
        end
        repeat (3) tick();
        check({tag, "_done_pulses"}, 32'(done_n - d0), ack ? 32'd1 : 32'd0);
        check({tag, "_err_pulses"}, 32'(err_n - e0), ack ? 32'd0 : 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_oe_after"}, 32'({key_clk_oe, key_din_oe}), 32'd0);
        repeat (50) tick();
    endtask

    initial begin
        int d0;
        int e0;
        int cnt;
        bit rel;
        logic smp;
        logic [7:0] rd;

        checks      = 0;
        failures    = 0;
        done_n      = 0;
        err_n       = 0;
        both_n      = 0;
        rst         = 1'b1;
        tx_data     = 8'h00;
        tx_start    = 1'b0;
        dev_clk_low = 1'b0;
        dev_din_low = 1'b0;
        repeat (5) tick();
        check("reset_outputs", 32'({key_clk_oe, key_din_oe, busy, done, err}), 32'd0);
        rst = 1'b0;
        repeat (20) tick();
        check("idle_outputs", 32'({key_clk_oe, key_din_oe, busy}), 32'd0);

        xfer(8'hED, 1'b1, 1'b0, 1'b0, "led_cmd");
        xfer(8'hFF, 1'b0, 1'b0, 1'b0, "nack");
        xfer(8'hF4, 1'b1, 1'b0, 1'b1, "restart_ignored");
        xfer(8'hF3, 1'b1, 1'b1, 1'b0, "glitch");

        // Device never clocks after release.
        e0 = err_n;
        d0 = done_n;
        start_and_release(8'hF2, "timeout", rel);
        cnt = 0;
        while (err_n == e0 && cnt < int'(TMO + 100)) begin
            tick();
            cnt++;
        end
        check("timeout_delay_ok", 32'(cnt >= int'(TMO - 2) && cnt <= int'(TMO + 2)), 32'd1);
        check("timeout_oe", 32'({key_clk_oe, key_din_oe}), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_no_done", 32'(done_n - d0), 32'd0);
        repeat (50) tick();

        // Reset in the middle of shifting.
        e0 = err_n;
        d0 = done_n;
        start_and_release(8'hA5, "midreset", rel);
        repeat (20) tick();
        for (int p = 0; p < 3; p++) pulse(1'b0, 1'b0, smp);
        rst = 1'b1;
        tick();
        check("midreset_oe", 32'({key_clk_oe, key_din_oe}), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (100) tick();
        check("midreset_no_pulse", 32'((done_n - d0) + (err_n - e0)), 32'd0);

        for (int i = 0; i < 4; i++) begin
            rd = 8'($urandom);
            xfer(rd, 1'($urandom), 1'($urandom), 1'b0, $sformatf("rand%0d", i));
        end

        check("never_both", 32'(both_n), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
